mpu6050_poll_sequencer: RTL and testbench
=========================================

Name: mpu6050_poll_sequencer

Overview:
- Transaction sequencer placed between the system and the I2C byte engine (i2c_driver) on the MPU-6050 path.
- After reset it runs a fixed three-write init table on the sensor.
- It then periodically burst-reads the accelerometer (0x3B, 6 bytes) and the gyro (0x43, 6 bytes).
- It retries NACKed transactions, publishes signed 16-bit samples with a valid strobe, and reports faults and poll overruns.

Parameters:
- SLAVE_ADDR, 7'h68, device address driven to the I2C engine.
- PWRUP_CYCLES, 16'd1200, clk cycles to wait after reset before the first transaction.
- POLL_DIV, 16'd1200, clk cycles per poll tick; legal range 2..65535.
- MAX_RETRY, 2, extra attempts per transaction after a NACK before entering FAULT.

Ports:
- clk  in  1  block clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- poll_en  in  1  enables the poll timer once init is complete.
- clear_fault  in  1  single-cycle pulse; leaves FAULT and re-runs init.
- run_req  out  1  transaction request to the I2C engine.
- slave_addr  out  7  constant SLAVE_ADDR.
- r_en  out  1  0 = register write, 1 = burst read.
- reg_addr  out  8  target register.
- send_data  out  8  write payload; 0 during reads.
- num_data  out  3  byte count: 1 for writes, 6 for reads.
- end_flag  in  1  one-cycle pulse from the engine when a transaction completes.
- ack_err  in  1  valid with end_flag; 1 = NACK seen.
- rx_data  in  64  read bytes; byte i is on [8i+7:8i], byte 0 received first.
- accel_x, accel_y, accel_z, gyro_x, gyro_y, gyro_z  out  16 each  signed samples.
- sample_valid  out  1  one-cycle pulse when all six sample outputs update.
- init_done  out  1  high once all init writes have been ACKed.
- fault  out  1  high while in FAULT.
- overrun  out  1  one-cycle pulse when a poll tick is dropped.
- busy  out  1  high in any ISSUE or WAIT state.

Behaviour:
- Reset values: all outputs 0 except slave_addr = SLAVE_ADDR. Reset takes effect immediately, including mid-transaction; run_req drops asynchronously, and retry count, timers and samples all clear.
- Init table:
  - entry 0: reg 0x6B, data 0x00
  - entry 1: reg 0x1C, data 0x08
  - entry 2: reg 0x1B, data 0x08
  - all entries: r_en = 0, num_data = 1.
- State machine:
  - PWRUP: count PWRUP_CYCLES, then go to INIT_ISSUE with index 0.
  - INIT_ISSUE: drive the fields for the current index, assert run_req, go to INIT_WAIT.
  - INIT_WAIT: hold run_req and all fields stable until end_flag.
    - ack_err = 0: index+1. After index 2, set init_done and go to IDLE; otherwise go to INIT_ISSUE.
  - IDLE: on a poll tick go to ACC_ISSUE (reg 0x3B, r_en = 1, num_data = 6).
  - ACC_WAIT: on a good end_flag, capture rx_data bytes 0..5 into a shadow register, then go to GYR_ISSUE (reg 0x43).
  - GYR_WAIT: on a good end_flag go to PUBLISH.
  - PUBLISH: one cycle. Load the outputs from the shadow and current rx_data, pulse sample_valid, return to IDLE.
  - FAULT: run_req = 0, fault = 1, init_done = 0. Stays until clear_fault, then goes to INIT_ISSUE with index 0. PWRUP is not repeated.
- Handshake rules:
  - run_req rises in the ISSUE state and falls in the cycle after end_flag.
  - run_req is low for at least 1 cycle between transactions.
  - end_flag outside a WAIT state is ignored.
- NACK handling:
  - end_flag with ack_err = 1 and retry count < MAX_RETRY: increment the count and return to the same ISSUE state.
  - Otherwise go to FAULT.
  - The retry count clears on every ACKed transaction.
  - Any NACK within a poll cycle discards that cycle: no partial publish.
- Sample assembly: big-endian, so accel_x = {b0,b1}, accel_y = {b2,b3}, accel_z = {b4,b5}; the gyro samples use the same byte order.
- Poll timer:
  - Runs only when init_done && poll_en; otherwise it holds at 0.
  - Counts 0..POLL_DIV-1; a tick fires at the wrap.
  - A tick arriving while not in IDLE is dropped and pulses overrun.
  - If poll_en drops mid-poll, the current poll cycle completes and publishes.
- clear_fault outside FAULT is ignored.

Test Plan:
- Reset release, engine ACKs everything → after PWRUP_CYCLES, three writes in order: (6B,00), (1C,08), (1B,08), each with num_data = 1; init_done rises 1 cycle after the third end_flag.
- poll_en = 1, rx_data = 64'h0000_6655_4433_2211 on both reads → accel_x = 0x1122, accel_y = 0x3344, accel_z = 0x5566, same values on the gyro; sample_valid pulses once per POLL_DIV cycles.
- NACK the first attempt of the 0x1C write, then ACK → 0x1C is reissued exactly once and init completes; fault stays 0.
- NACK 0x3B three consecutive times (MAX_RETRY = 2) → FAULT, no sample_valid; clear_fault → init sequence restarts at 0x6B.
- Engine stretches the gyro read beyond POLL_DIV cycles → overrun pulses once, the sample is still published, and the next poll starts on the following tick.
- Assert rst_n low during ACC_WAIT → run_req and all outputs drop immediately; after release, PWRUP is repeated.

Source files
------------

// File: rtl/mpu6050_poll_sequencer_if.sv
// Transaction bus between the MPU-6050 poll sequencer (master) and the I2C byte engine (slave).
interface mpu6050_poll_sequencer_if;
  logic        run_req;
  logic [6:0]  slave_addr;
  logic        r_en;
  logic [7:0]  reg_addr;
  logic [7:0]  send_data;
  logic [2:0]  num_data;
  logic        end_flag;
  logic        ack_err;
  logic [63:0] rx_data;

  modport master (
    output run_req, slave_addr, r_en, reg_addr, send_data, num_data,
    input  end_flag, ack_err, rx_data
  );

  modport slave (
    input  run_req, slave_addr, r_en, reg_addr, send_data, num_data,
    output end_flag, ack_err, rx_data
  );
endinterface

// File: rtl/mpu6050_poll_sequencer.sv
// MPU-6050 sequencer: power-up wait, three-write init, then periodic accel/gyro burst reads
// with NACK retry, fault latching and poll-overrun reporting.
module mpu6050_poll_sequencer #(
  parameter logic [6:0]  SLAVE_ADDR   = 7'h68,
  parameter logic [15:0] PWRUP_CYCLES = 16'd1200,
  parameter logic [15:0] POLL_DIV     = 16'd1200,
  parameter int unsigned MAX_RETRY    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     poll_en,
  input  logic                     clear_fault,
  mpu6050_poll_sequencer_if.master bus,
  output logic signed [15:0]       accel_x,
  output logic signed [15:0]       accel_y,
  output logic signed [15:0]       accel_z,
  output logic signed [15:0]       gyro_x,
  output logic signed [15:0]       gyro_y,
  output logic signed [15:0]       gyro_z,
  output logic                     sample_valid,
  output logic                     init_done,
  output logic                     fault,
  output logic                     overrun,
  output logic                     busy
);

  typedef enum logic [3:0] {
    S_PWRUP, S_INIT_ISSUE, S_INIT_WAIT, S_IDLE, S_ACC_ISSUE, S_ACC_WAIT,
    S_GYR_ISSUE, S_GYR_WAIT, S_PUBLISH, S_FAULT
  } state_t;

  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

  state_t      state, state_nxt;
  logic [1:0]  idx;
  logic [3:0]  retry_cnt;
  logic [15:0] pwr_cnt;
  logic [15:0] poll_cnt;
  logic [47:0] acc_shadow;
  logic [7:0]  iss_reg, iss_data;
  logic        iss_rd;
  logic [2:0]  iss_num;
  logic        good_end, nack_end, can_retry, in_wait, in_issue;
  logic        poll_run, poll_tick, pwr_last;
  logic        unused_rx;

  function automatic logic signed [15:0] be16(input logic [7:0] hi, input logic [7:0] lo);
    return signed'({hi, lo});
  endfunction

  assign good_end   = bus.end_flag & ~bus.ack_err;
  assign nack_end   = bus.end_flag &  bus.ack_err;
  assign can_retry  = retry_cnt < RETRY_LIM;
  assign in_wait    = (state == S_INIT_WAIT) || (state == S_ACC_WAIT) || (state == S_GYR_WAIT);
  assign in_issue   = (state == S_INIT_ISSUE) || (state == S_ACC_ISSUE) || (state == S_GYR_ISSUE);
  assign poll_run   = init_done & poll_en;
  assign poll_tick  = poll_run && (poll_cnt == POLL_DIV - 16'd1);
  assign pwr_last   = ({1'b0, pwr_cnt} + 17'd1) >= {1'b0, PWRUP_CYCLES};
  assign busy       = in_issue | in_wait;
  assign fault      = (state == S_FAULT);
  assign bus.slave_addr = SLAVE_ADDR;
  assign unused_rx  = ^bus.rx_data[63:48];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_PWRUP;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    iss_reg   = 8'h00;
    iss_data  = 8'h00;
    iss_rd    = 1'b0;
    iss_num   = 3'd1;
    case (state)
      S_PWRUP:      if (pwr_last) state_nxt = S_INIT_ISSUE;
      S_INIT_ISSUE: begin
        state_nxt = S_INIT_WAIT;
        case (idx)
          2'd0:    begin iss_reg = 8'h6B; iss_data = 8'h00; end
          2'd1:    begin iss_reg = 8'h1C; iss_data = 8'h08; end
          default: begin iss_reg = 8'h1B; iss_data = 8'h08; end
        endcase
      end
      S_INIT_WAIT: begin
        if (good_end)      state_nxt = (idx == 2'd2) ? S_IDLE : S_INIT_ISSUE;
        else if (nack_end) state_nxt = can_retry ? S_INIT_ISSUE : S_FAULT;
      end
      S_IDLE:       if (poll_tick) state_nxt = S_ACC_ISSUE;
      S_ACC_ISSUE: begin
        state_nxt = S_ACC_WAIT;
        iss_reg = 8'h3B; iss_rd = 1'b1; iss_num = 3'd6;
      end
      S_ACC_WAIT: begin
        if (good_end)      state_nxt = S_GYR_ISSUE;
        else if (nack_end) state_nxt = can_retry ? S_ACC_ISSUE : S_FAULT;
      end
      S_GYR_ISSUE: begin
        state_nxt = S_GYR_WAIT;
        iss_reg = 8'h43; iss_rd = 1'b1; iss_num = 3'd6;
      end
      S_GYR_WAIT: begin
        if (good_end)      state_nxt = S_PUBLISH;
        else if (nack_end) state_nxt = can_retry ? S_GYR_ISSUE : S_FAULT;
      end
      S_PUBLISH:    state_nxt = S_IDLE;
      S_FAULT:      if (clear_fault) state_nxt = S_INIT_ISSUE;
      default:      state_nxt = S_PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.run_req   <= 1'b0;
      bus.r_en      <= 1'b0;
      bus.reg_addr  <= 8'h00;
      bus.send_data <= 8'h00;
      bus.num_data  <= 3'd0;
      idx           <= 2'd0;
      retry_cnt     <= 4'd0;
      pwr_cnt       <= 16'd0;
      poll_cnt      <= 16'd0;
      acc_shadow    <= 48'd0;
      accel_x       <= 16'sd0;
      accel_y       <= 16'sd0;
      accel_z       <= 16'sd0;
      gyro_x        <= 16'sd0;
      gyro_y        <= 16'sd0;
      gyro_z        <= 16'sd0;
      sample_valid  <= 1'b0;
      init_done     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      overrun      <= poll_tick && (state != S_IDLE);

      if (state == S_PWRUP) pwr_cnt <= pwr_cnt + 16'd1;

      if (!poll_run || poll_tick) poll_cnt <= 16'd0;
      else                        poll_cnt <= poll_cnt + 16'd1;

      // Fields latch in ISSUE and stay frozen until the engine reports completion
      if (in_issue) begin
        bus.run_req   <= 1'b1;
        bus.r_en      <= iss_rd;
        bus.reg_addr  <= iss_reg;
        bus.send_data <= iss_data;
        bus.num_data  <= iss_num;
      end

      if (in_wait && bus.end_flag) begin
        bus.run_req <= 1'b0;
        if (!bus.ack_err || !can_retry) retry_cnt <= 4'd0;
        else                            retry_cnt <= retry_cnt + 4'd1;
      end

      if (state == S_INIT_WAIT && good_end) begin
        idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        if (idx == 2'd2) init_done <= 1'b1;
      end

      if (state == S_ACC_WAIT && good_end) acc_shadow <= bus.rx_data[47:0];

      if (state == S_PUBLISH) begin
        accel_x      <= be16(acc_shadow[7:0],   acc_shadow[15:8]);
        accel_y      <= be16(acc_shadow[23:16], acc_shadow[31:24]);
        accel_z      <= be16(acc_shadow[39:32], acc_shadow[47:40]);
        gyro_x       <= be16(bus.rx_data[7:0],   bus.rx_data[15:8]);
        gyro_y       <= be16(bus.rx_data[23:16], bus.rx_data[31:24]);
        gyro_z       <= be16(bus.rx_data[39:32], bus.rx_data[47:40]);
        sample_valid <= 1'b1;
      end

      if (state_nxt == S_FAULT) begin
        init_done <= 1'b0;
        idx       <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_mpu6050_poll_sequencer.sv
// Directed bench for mpu6050_poll_sequencer with a scripted I2C engine responder.
module tb_mpu6050_poll_sequencer;
  localparam logic [15:0] PWR = 16'd8;
  localparam logic [15:0] DIV = 16'd40;
  localparam logic [63:0] RX_A = 64'h0000_6655_4433_2211;
  localparam logic [63:0] RX_G = 64'h0000_CCDD_AABB_8899;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic poll_en = 1'b0;
  logic clear_fault = 1'b0;
  logic signed [15:0] ax, ay, az, gx, gy, gz;
  logic sample_valid, init_done, fault, overrun, busy;
  int tests = 0;
  int fails = 0;
  int cyc = 0, sv_cnt = 0, sv_last = 0, sv_prev = 0, ov_cnt = 0;

  mpu6050_poll_sequencer_if bif();

  mpu6050_poll_sequencer #(
    .SLAVE_ADDR(7'h68), .PWRUP_CYCLES(PWR), .POLL_DIV(DIV), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .poll_en(poll_en), .clear_fault(clear_fault), .bus(bif),
    .accel_x(ax), .accel_y(ay), .accel_z(az), .gyro_x(gx), .gyro_y(gy), .gyro_z(gz),
    .sample_valid(sample_valid), .init_done(init_done), .fault(fault),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sample_valid) begin
      sv_cnt  <= sv_cnt + 1;
      sv_prev <= sv_last;
      sv_last <= cyc;
    end
    if (overrun) ov_cnt <= ov_cnt + 1;
  end

  // Waits (bounded) for run_req, records the request, answers after lat cycles.
  task automatic serve(input logic nack, input int lat, input logic [63:0] rx,
                       output logic got, output int waited, output int t_req,
                       output logic [15:0] fld, output logic rd, output logic [2:0] n,
                       output logic fell, output logic stb);
    got = 1'b0; waited = 0; t_req = 0; fld = 16'h0; rd = 1'b0; n = 3'd0; fell = 1'b0; stb = 1'b0;
    while (!got && waited < 400) begin
      @(negedge clk);
      waited++;
      if (bif.run_req === 1'b1) got = 1'b1;
    end
    if (got) begin
      t_req = cyc;
      fld = {bif.reg_addr, bif.send_data};
      rd = bif.r_en;
      n = bif.num_data;
      repeat (lat) @(negedge clk);
      stb = (bif.run_req === 1'b1) && ({bif.reg_addr, bif.send_data} === fld)
            && (bif.r_en === rd) && (bif.num_data === n);
      bif.rx_data = rx; bif.end_flag = 1'b1; bif.ack_err = nack;
      @(negedge clk);
      bif.end_flag = 1'b0; bif.ack_err = 1'b0;
      fell = (bif.run_req === 1'b0);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bif.run_req, bif.r_en, bif.reg_addr, bif.send_data, bif.num_data, sample_valid,
         init_done, fault, overrun, busy} !== 26'd0) begin
      fails++; $display("FAIL reset_ctrl: got %h expected 0", {bif.run_req, bif.r_en,
        bif.reg_addr, bif.send_data, bif.num_data, sample_valid, init_done, fault, overrun, busy});
    end
    tests++;
    if ({ax, ay, az, gx, gy, gz} !== 96'd0 || bif.slave_addr !== 7'h68) begin
      fails++; $display("FAIL reset_data: samples %h addr %h expected 0 / 68",
        {ax, ay, az, gx, gy, gz}, bif.slave_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_init;
    logic [15:0] exp_f [3] = '{16'h6B00, 16'h1C08, 16'h1B08};
    logic got, rd, fell, stb; int w, t; logic [15:0] f; logic [2:0] n;
    for (int i = 0; i < 3; i++) begin
      serve(1'b0, 2, 64'd0, got, w, t, f, rd, n, fell, stb);
      tests++;
      if ({got, f, rd, n, fell, stb} !== {1'b1, exp_f[i], 1'b0, 3'd1, 1'b1, 1'b1}) begin
        fails++; $display("FAIL init_wr%0d: got %h expected %h", i,
          {got, f, rd, n, fell, stb}, {1'b1, exp_f[i], 1'b0, 3'd1, 1'b1, 1'b1});
      end
      if (i == 0) begin
        tests++;
        if (w !== 9) begin fails++; $display("FAIL pwrup_wait: got %0d expected 9", w); end
      end
      tests++;
      if (init_done !== (i == 2)) begin
        fails++; $display("FAIL init_done%0d: got %b expected %b", i, init_done, i == 2);
      end
    end
    tests++;
    if (fault !== 1'b0) begin fails++; $display("FAIL init_fault: got %b expected 0", fault); end
  endtask

  task automatic test_poll;
    logic got, rd, fell, stb; int w, t; logic [15:0] f; logic [2:0] n;
    poll_en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      serve(1'b0, 2, (p == 0) ? RX_A : RX_G, got, w, t, f, rd, n, fell, stb);
      tests++;
      if ({got, f, rd, n, fell, stb} !== {1'b1, 16'h3B00, 1'b1, 3'd6, 1'b1, 1'b1}) begin
        fails++; $display("FAIL acc_req%0d: got %h expected %h", p,
          {got, f, rd, n, fell, stb}, {1'b1, 16'h3B00, 1'b1, 3'd6, 1'b1, 1'b1});
      end
      serve(1'b0, 3, RX_A, got, w, t, f, rd, n, fell, stb);
      tests++;
      if ({got, f, rd, n, fell, stb} !== {1'b1, 16'h4300, 1'b1, 3'd6, 1'b1, 1'b1}) begin
        fails++; $display("FAIL gyr_req%0d: got %h expected %h", p,
          {got, f, rd, n, fell, stb}, {1'b1, 16'h4300, 1'b1, 3'd6, 1'b1, 1'b1});
      end
      @(negedge clk);
      tests++;
      if (sample_valid !== 1'b1) begin
        fails++; $display("FAIL sv_pulse%0d: got %b expected 1", p, sample_valid);
      end
      tests++;
      if (p == 0 && {ax, ay, az, gx, gy, gz} !== 96'h1122_3344_5566_1122_3344_5566) begin
        fails++; $display("FAIL samples0: got %h expected 112233445566112233445566",
          {ax, ay, az, gx, gy, gz});
      end else if (p == 1 && {ax, ay, az, gx, gy, gz} !== 96'h9988_BBAA_DDCC_1122_3344_5566) begin
        fails++; $display("FAIL samples1: got %h expected 9988bbaaddcc112233445566",
          {ax, ay, az, gx, gy, gz});
      end
      @(negedge clk);
      tests++;
      if (sample_valid !== 1'b0) begin
        fails++; $display("FAIL sv_width%0d: got %b expected 0", p, sample_valid);
      end
      if (p == 0) begin
        bif.end_flag = 1'b1; bif.ack_err = 1'b1;
        @(negedge clk);
        bif.end_flag = 1'b0; bif.ack_err = 1'b0;
        @(negedge clk);
        tests++;
        if ({fault, busy} !== 2'b00) begin
          fails++; $display("FAIL stray_end: fault/busy %b expected 00", {fault, busy});
        end
      end
    end
    tests++;
    if (sv_last - sv_prev !== 40) begin
      fails++; $display("FAIL poll_period: got %0d expected 40", sv_last - sv_prev);
    end
  endtask

  task automatic test_overrun;
    logic got, rd, fell, stb; int w, t1, t2, ov0; logic [15:0] f; logic [2:0] n;
    ov0 = ov_cnt;
    serve(1'b0, 2, RX_A, got, w, t1, f, rd, n, fell, stb);
    serve(1'b0, 50, RX_G, got, w, t2, f, rd, n, fell, stb);
    @(negedge clk);
    tests++;
    if ({sample_valid, gx} !== {1'b1, 16'h9988}) begin
      fails++; $display("FAIL ovr_publish: got %h expected 19988", {sample_valid, gx});
    end
    serve(1'b0, 2, RX_A, got, w, t2, f, rd, n, fell, stb);
    tests++;
    if ({got, f} !== {1'b1, 16'h3B00} || t2 - t1 !== 80) begin
      fails++; $display("FAIL ovr_next_tick: req %h spacing %0d expected 13b00 / 80", {got, f}, t2 - t1);
    end
    tests++;
    if (ov_cnt - ov0 !== 1) begin
      fails++; $display("FAIL ovr_count: got %0d expected 1", ov_cnt - ov0);
    end
    poll_en = 1'b0;
    serve(1'b0, 2, RX_G, got, w, t2, f, rd, n, fell, stb);
    @(negedge clk);
    tests++;
    if ({sample_valid, gx} !== {1'b1, 16'h9988}) begin
      fails++; $display("FAIL pollen_drop: got %h expected 19988", {sample_valid, gx});
    end
  endtask

  task automatic test_fault_retry;
    logic [15:0] exp_f [4] = '{16'h6B00, 16'h1C08, 16'h1C08, 16'h1B08};
    logic        nk [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic got, rd, fell, stb; int w, t, sv0; logic [15:0] f; logic [2:0] n;
    poll_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      serve(1'b1, 1, RX_A, got, w, t, f, rd, n, fell, stb);
      if (k == 0) sv0 = sv_cnt;
      tests++;
      if ({got, f, rd, n, fell} !== {1'b1, 16'h3B00, 1'b1, 3'd6, 1'b1}) begin
        fails++; $display("FAIL nack_try%0d: got %h expected %h", k,
          {got, f, rd, n, fell}, {1'b1, 16'h3B00, 1'b1, 3'd6, 1'b1});
      end
    end
    tests++;
    if ({fault, init_done, bif.run_req, busy} !== 4'b1000) begin
      fails++; $display("FAIL fault_entry: got %b expected 1000",
        {fault, init_done, bif.run_req, busy});
    end
    repeat (100) @(negedge clk);
    tests++;
    if (sv_cnt !== sv0 || {fault, bif.run_req} !== 2'b10) begin
      fails++; $display("FAIL fault_hold: sv %0d->%0d fault/run %b expected same / 10",
        sv0, sv_cnt, {fault, bif.run_req});
    end
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serve(nk[i], 1, 64'd0, got, w, t, f, rd, n, fell, stb);
      tests++;
      if ({got, f, rd, n, fell} !== {1'b1, exp_f[i], 1'b0, 3'd1, 1'b1}) begin
        fails++; $display("FAIL reinit%0d: got %h expected %h", i,
          {got, f, rd, n, fell}, {1'b1, exp_f[i], 1'b0, 3'd1, 1'b1});
      end
    end
    tests++;
    if ({init_done, fault} !== 2'b10) begin
      fails++; $display("FAIL reinit_done: got %b expected 10", {init_done, fault});
    end
  endtask

  task automatic test_reset_midflight;
    logic got, rd, fell, stb; int w, t; logic [15:0] f; logic [2:0] n;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (bif.run_req === 1'b1) got = 1'b1;
    end
    tests++;
    if ({got, bif.reg_addr} !== {1'b1, 8'h3B}) begin
      fails++; $display("FAIL mid_acc_wait: got %h expected 13b", {got, bif.reg_addr});
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bif.run_req, bif.reg_addr, bif.num_data, ax, gz, sample_valid, init_done, fault, busy}
        !== 48'd0 || bif.slave_addr !== 7'h68) begin
      fails++; $display("FAIL async_reset: got %h addr %h expected 0 / 68",
        {bif.run_req, bif.reg_addr, bif.num_data, ax, gz, sample_valid, init_done, fault, busy},
        bif.slave_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    serve(1'b0, 1, 64'd0, got, w, t, f, rd, n, fell, stb);
    tests++;
    if ({got, f} !== {1'b1, 16'h6B00} || w !== 9) begin
      fails++; $display("FAIL pwrup_repeat: req %h wait %0d expected 16b00 / 9", {got, f}, w);
    end
  endtask

  initial begin
    bif.end_flag = 1'b0;
    bif.ack_err  = 1'b0;
    bif.rx_data  = 64'd0;
    test_reset();
    test_init();
    test_poll();
    test_overrun();
    test_fault_retry();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
